// File: rtl/fighter_pkg.sv
// Shared fighter encodings: action states, attack codes and default frame counts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_JUMP     = 3'd1,
        ST_STARTUP  = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_RECOVERY = 3'd4,
        ST_HITSTUN  = 3'd5
    } act_state_t;

    typedef enum logic [1:0] {
        ATK_NONE  = 2'd0,
        ATK_PUNCH = 2'd1,
        ATK_KICK  = 2'd2
    } atk_type_t;

    // Defaults shared with sprite_mapper and the hit detector.
    localparam int DEF_STARTUP_FRAMES  = 3;
    localparam int DEF_ACTIVE_FRAMES   = 2;
    localparam int DEF_RECOVERY_FRAMES = 6;
    localparam int DEF_HITSTUN_FRAMES  = 12;
    localparam int DEF_CNT_WIDTH       = 5;

    // Punch wins over kick when both requests land in the same frame.
    function automatic atk_type_t atk_pick(input logic punch, input logic kick);
        atk_type_t res;
        res = ATK_NONE;
        if (punch) begin
            res = ATK_PUNCH;
        end else if (kick) begin
            res = ATK_KICK;
        end
        return res;
    endfunction

endpackage

// File: rtl/input_latch.sv
// Rising-edge detector with a sticky pending flag that clears on every frame strobe.
// Latency: req is combinational (pending OR edge in this clk), so an edge on a SCEN clk counts for that SCEN.
// Backpressure: none; requests not consumed on a SCEN are dropped.
module input_latch (
    input  logic clk,
    input  logic reset,
    input  logic scen,
    input  logic din,
    output logic req
);

    logic hist_q;
    logic pend_q;
    logic rise;

    assign rise = din & ~hist_q;
    assign req  = pend_q | rise;

    // History resets high so a button held through reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            hist_q <= din;
            pend_q <= scen ? 1'b0 : req;
        end
    end

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer: one exclusive action per frame (hit > attack > jump > move); optional ATK_BUFFER_EN buffers attacks pressed in recovery.
// Latency: outputs registered, updated on the clk where SCEN is high and held for the following frame.
// Backpressure: none; inputs not usable in the current state are discarded at the frame strobe.
module player_action_ctrl
    import fighter_pkg::*;
#(
    parameter int STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
    parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
    parameter int RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
    parameter int HITSTUN_FRAMES  = DEF_HITSTUN_FRAMES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       hit_taken,
    input  logic       jump_active,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       atk_valid,
    output logic [1:0] atk_type,
    output logic [2:0] act_state,
    output logic       busy
);

    localparam logic [CNT_WIDTH-1:0] LD_STARTUP  = CNT_WIDTH'(STARTUP_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_ACTIVE   = CNT_WIDTH'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_RECOVERY = CNT_WIDTH'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_HITSTUN  = CNT_WIDTH'(HITSTUN_FRAMES - 1);
    // Takeoff grace: leave JUMP if player_move never reports airborne within 2 frames.
    localparam logic [CNT_WIDTH-1:0] LD_JUMP     = CNT_WIDTH'(1);

    logic jump_req, punch_req, kick_req, hit_req;
    logic dir_l, dir_r;

    act_state_t           state_q, state_d;
    atk_type_t            atk_type_q, atk_type_d, atk_sel;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 seen_air_q, seen_air_d, air;
    logic                 move_left_d, move_right_d, jump_d;
`ifdef ATK_BUFFER_EN
    atk_type_t            buf_q, buf_d;
`endif

    input_latch u_jump  (.clk(clk), .reset(reset), .scen(SCEN), .din(btn_jump),  .req(jump_req));
    input_latch u_punch (.clk(clk), .reset(reset), .scen(SCEN), .din(btn_punch), .req(punch_req));
    input_latch u_kick  (.clk(clk), .reset(reset), .scen(SCEN), .din(btn_kick),  .req(kick_req));
    input_latch u_hit   (.clk(clk), .reset(reset), .scen(SCEN), .din(hit_taken), .req(hit_req));

    assign dir_l = btn_left & ~btn_right;
    assign dir_r = btn_right & ~btn_left;

    // Next-state and next-output decision, evaluated as if this clk were a frame strobe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == '0) ? '0 : cnt_q - CNT_WIDTH'(1);
        seen_air_d   = seen_air_q;
        atk_type_d   = atk_type_q;
        move_left_d  = 1'b0;
        move_right_d = 1'b0;
        jump_d       = 1'b0;
        air          = seen_air_q | jump_active;
        atk_sel      = atk_pick(punch_req, kick_req);
`ifdef ATK_BUFFER_EN
        buf_d        = buf_q;
        if (atk_sel == ATK_NONE) begin
            atk_sel = buf_q;
        end
`endif
        if (hit_req) begin
            state_d    = ST_HITSTUN;
            cnt_d      = LD_HITSTUN;
            atk_type_d = ATK_NONE;
            seen_air_d = 1'b0;
`ifdef ATK_BUFFER_EN
            buf_d      = ATK_NONE;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (atk_sel != ATK_NONE) begin
                        state_d    = ST_STARTUP;
                        cnt_d      = LD_STARTUP;
                        atk_type_d = atk_sel;
`ifdef ATK_BUFFER_EN
                        buf_d      = ATK_NONE;
`endif
                    end else if (jump_req) begin
                        state_d      = ST_JUMP;
                        cnt_d        = LD_JUMP;
                        seen_air_d   = 1'b0;
                        jump_d       = 1'b1;
                        move_left_d  = dir_l;
                        move_right_d = dir_r;
                    end else begin
                        move_left_d  = dir_l;
                        move_right_d = dir_r;
                    end
                end
                ST_JUMP: begin
                    seen_air_d = air;
                    if (air && !jump_active) begin
                        state_d = ST_IDLE;
                    end else if (!air && cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STARTUP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = LD_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RECOVERY;
                        cnt_d   = LD_RECOVERY;
                    end
                end
                ST_RECOVERY: begin
`ifdef ATK_BUFFER_EN
                    if (atk_pick(punch_req, kick_req) != ATK_NONE) begin
                        buf_d = atk_pick(punch_req, kick_req);
                    end
`endif
                    if (cnt_q == '0) begin
                        state_d    = ST_IDLE;
                        atk_type_d = ATK_NONE;
                    end
                end
                ST_HITSTUN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    atk_type_d = ATK_NONE;
                end
            endcase
        end
    end

    // State, counter and registered outputs advance only on frame strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seen_air_q <= 1'b0;
            atk_type_q <= ATK_NONE;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            jump       <= 1'b0;
            atk_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef ATK_BUFFER_EN
            buf_q      <= ATK_NONE;
`endif
        end else if (SCEN) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_air_q <= seen_air_d;
            atk_type_q <= atk_type_d;
            move_left  <= move_left_d;
            move_right <= move_right_d;
            jump       <= jump_d;
            atk_valid  <= (state_d == ST_ACTIVE);
            busy       <= (state_d != ST_IDLE);
`ifdef ATK_BUFFER_EN
            buf_q      <= buf_d;
`endif
        end
    end

    assign act_state = state_q;
    assign atk_type  = atk_type_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Testbench for player_action_ctrl: directed scenarios plus random stimulus against a frame-age reference model.
// Latency: outputs sampled #1 after the clk edge and on every falling edge.
// Backpressure: n/a.
module tb_player_action_ctrl;

    localparam int ST_F  = 3;
    localparam int AC_F  = 2;
    localparam int RC_F  = 6;
    localparam int HIT_F = 12;
    localparam int TOTAL = ST_F + AC_F + RC_F;

    localparam int M_IDLE = 0;
    localparam int M_JUMP = 1;
    localparam int M_ATK  = 2;
    localparam int M_HIT  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SCEN = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic       btn_punch = 1'b0, btn_kick = 1'b0, hit_taken = 1'b0, jump_active = 1'b0;
    logic       move_left, move_right, jump, atk_valid, busy;
    logic [1:0] atk_type;
    logic [2:0] act_state;

    int checks = 0;
    int errors = 0;

    player_action_ctrl dut (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .btn_punch(btn_punch), .btn_kick(btn_kick), .hit_taken(hit_taken),
        .jump_active(jump_active),
        .move_left(move_left), .move_right(move_right), .jump(jump),
        .atk_valid(atk_valid), .atk_type(atk_type), .act_state(act_state), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an action is tracked by how many frames have passed since it began.
    int mode = M_IDLE, age = 0, m_atk = 0, buff = 0;
    bit air = 0, m_ml = 0, m_mr = 0, m_jp = 0;
    bit p_j = 1, p_p = 1, p_k = 1, p_h = 1;
    bit q_j = 0, q_p = 0, q_k = 0, q_h = 0;

    function automatic int m_act();
        if (mode == M_ATK) begin
            if (age < ST_F) return 2;
            if (age < ST_F + AC_F) return 3;
            return 4;
        end
        return mode;
    endfunction

    always @(posedge clk) begin
        bit rj, rp, rk, rh, dl, dr;
        int a;
        if (reset) begin
            mode = M_IDLE; age = 0; m_atk = 0; buff = 0; air = 0;
            m_ml = 0; m_mr = 0; m_jp = 0;
            p_j = 1; p_p = 1; p_k = 1; p_h = 1;
            q_j = 0; q_p = 0; q_k = 0; q_h = 0;
        end else begin
            rj = q_j | (btn_jump & ~p_j);
            rp = q_p | (btn_punch & ~p_p);
            rk = q_k | (btn_kick & ~p_k);
            rh = q_h | (hit_taken & ~p_h);
            p_j = btn_jump; p_p = btn_punch; p_k = btn_kick; p_h = hit_taken;
            dl = btn_left & ~btn_right;
            dr = btn_right & ~btn_left;
            if (SCEN) begin
                m_ml = 0; m_mr = 0; m_jp = 0;
                if (rh) begin
                    mode = M_HIT; age = 0; m_atk = 0; buff = 0;
                end else begin
                    case (mode)
                        M_IDLE: begin
                            a = rp ? 1 : (rk ? 2 : buff);
                            if (a != 0) begin
                                mode = M_ATK; age = 0; m_atk = a; buff = 0;
                            end else if (rj) begin
                                mode = M_JUMP; age = 0; air = 0; m_jp = 1; m_ml = dl; m_mr = dr;
                            end else begin
                                m_ml = dl; m_mr = dr;
                            end
                        end
                        M_JUMP: begin
                            age++;
                            if (jump_active) air = 1;
                            if (air && !jump_active) mode = M_IDLE;
                            else if (!air && age >= 2) mode = M_IDLE;
                        end
                        M_ATK: begin
`ifdef ATK_BUFFER_EN
                            if (age >= ST_F + AC_F && (rp || rk)) buff = rp ? 1 : 2;
`endif
                            age++;
                            if (age == TOTAL) begin
                                mode = M_IDLE; m_atk = 0;
                            end
                        end
                        default: begin
                            age++;
                            if (age == HIT_F) mode = M_IDLE;
                        end
                    endcase
                end
                q_j = 0; q_p = 0; q_k = 0; q_h = 0;
            end else begin
                q_j = rj; q_p = rp; q_k = rk; q_h = rh;
            end
        end
    end

    // Every falling edge: full output comparison against the model.
    always @(negedge clk) begin
        chk("state", act_state, m_act());
        chk("atk_valid", atk_valid, int'(m_act() == 3));
        chk("atk_type", atk_type, m_atk);
        chk("move_left", move_left, m_ml);
        chk("move_right", move_right, m_mr);
        chk("jump", jump, m_jp);
        chk("busy", busy, int'(m_act() != 0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        SCEN = 1'b1;
        cyc();
        SCEN = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic pulse_punch();
        btn_punch = 1'b1; cyc(); btn_punch = 1'b0; cyc();
    endtask

    initial begin
        // Button held through reset must not fire.
        btn_punch = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        frame();
        chk("held_through_reset", act_state, 0);
        chk("reset_atk_type", atk_type, 0);
        btn_punch = 1'b0; cyc();
        btn_punch = 1'b1; cyc();
        frame();
        chk("punch_accept_state", act_state, 2);
        chk("punch_accept_type", atk_type, 1);
        btn_punch = 1'b0;
        repeat (3) frame();
        chk("punch_active", atk_valid, 1);
        repeat (2) frame();
        chk("punch_recovery", act_state, 4);
        repeat (5) frame();
        chk("punch_before_idle", act_state, 4);
        frame();
        chk("punch_idle", act_state, 0);

        // Direction resolution.
        btn_left = 1'b1; btn_right = 1'b1;
        frame();
        chk("both_dirs_l", move_left, 0);
        chk("both_dirs_r", move_right, 0);
        btn_right = 1'b0;
        frame();
        chk("left_only", move_left, 1);
        btn_left = 1'b0;
        frame();

        // Jump with drift, mid-air punch ignored.
        btn_jump = 1'b1; btn_right = 1'b1;
        frame();
        chk("takeoff_state", act_state, 1);
        chk("takeoff_jump", jump, 1);
        chk("takeoff_drift", move_right, 1);
        btn_jump = 1'b0; btn_right = 1'b0;
        jump_active = 1'b1;
        repeat (8) frame();
        pulse_punch();
        repeat (8) frame();
        chk("airborne_state", act_state, 1);
        chk("airborne_no_atk", atk_type, 0);
        jump_active = 1'b0;
        frame();
        chk("landed", act_state, 0);

        // Hit during ACTIVE, then a re-hit restarts hitstun.
        pulse_punch();
        frame();
        repeat (3) frame();
        chk("pre_hit_active", act_state, 3);
        hit_taken = 1'b1; cyc(); hit_taken = 1'b0;
        frame();
        chk("hit_state", act_state, 5);
        chk("hit_atk_valid", atk_valid, 0);
        chk("hit_atk_type", atk_type, 0);
        repeat (4) frame();
        hit_taken = 1'b1; cyc(); hit_taken = 1'b0;
        frame();
        repeat (11) frame();
        chk("rehit_still_stun", act_state, 5);
        frame();
        chk("rehit_idle", act_state, 0);

        // Kick pressed in RECOVERY.
        pulse_punch();
        frame();
        repeat (5) frame();
        chk("buf_in_recovery", act_state, 4);
        btn_kick = 1'b1; cyc(); btn_kick = 1'b0;
        repeat (6) frame();
        chk("buf_idle", act_state, 0);
        frame();
`ifdef ATK_BUFFER_EN
        chk("buf_fire_state", act_state, 2);
        chk("buf_fire_type", atk_type, 2);
`else
        chk("buf_discard_state", act_state, 0);
        chk("buf_discard_type", atk_type, 0);
`endif
        repeat (15) frame();

        // Random phase, including occasional mid-operation reset.
        for (int i = 0; i < 6000; i++) begin
            SCEN      = ($urandom_range(0, 3) == 0);
            hit_taken = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 9) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 7) == 0) btn_jump  = ~btn_jump;
            if ($urandom_range(0, 11) == 0) btn_punch = ~btn_punch;
            if ($urandom_range(0, 11) == 0) btn_kick  = ~btn_kick;
            if ($urandom_range(0, 5) == 0) jump_active = ~jump_active;
            reset = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        reset = 1'b0;
        SCEN = 1'b0;
        hit_taken = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
